// File: rtl/lc2k_prog_loader.sv
// lc2k_prog_loader: assembles a big-endian byte stream into 32-bit words and writes the LC2K instruction memory.
// Latency: mem_we pulses the cycle after a word's 4th byte is accepted; done pulses the cycle after the last write.
// Backpressure: in_ready is low outside LEN/DATA/CSUM and during every write cycle, so at most 4 bytes per 5 cycles.
// Optional: define LC2K_LOADER_CSUM_EN to require a trailing 32-bit additive checksum after the data words.
module lc2k_prog_loader #(
    parameter int ADDR_W    = 4,
    parameter int MAX_WORDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         shift_q, shift_d;
    logic [31:0]         len_q, len_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
`ifdef LC2K_LOADER_CSUM_EN
    logic [31:0]         acc_q, acc_d;
`endif

    logic                accept;
    logic [31:0]         word;
    logic                last_byte;

    // in_ready decodes only state and the write-cycle flag, never in_valid
    always_comb begin
        in_ready = ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM)) && !mem_we_q;
    end

    // Next-state, byte assembly and registered-output computation
    always_comb begin
        accept         = in_valid && in_ready;
        word           = {shift_q[23:0], in_data};
        last_byte      = accept && (byte_cnt_q == 2'd3);

        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        shift_d        = shift_q;
        len_d          = len_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cpu_hold_d     = cpu_hold_q;
        done_d         = 1'b0;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;
`ifdef LC2K_LOADER_CSUM_EN
        acc_d          = acc_q;
`endif

        if (accept) begin
            shift_d    = word;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                // A byte presented alongside start is not consumed: in_ready is low here
                if (start) begin
                    state_d        = S_LEN;
                    cpu_hold_d     = 1'b1;
                    err_d          = 1'b0;
                    words_loaded_d = '0;
                    byte_cnt_d     = 2'd0;
`ifdef LC2K_LOADER_CSUM_EN
                    acc_d          = '0;
`endif
                end
            end

            S_LEN: begin
                if (last_byte) begin
                    len_d = word;
                    if (word == 32'd0) begin
`ifdef LC2K_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else if (word > MAX_N) begin
                        // Oversize programs are rejected before any write happens
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (mem_we_q) begin
                    // Write cycle: words_loaded already counts this word
                    if (32'(words_loaded_q) == len_q) begin
`ifdef LC2K_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end else if (last_byte) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = words_loaded_q[ADDR_W-1:0];
                    mem_wdata_d    = word;
                    words_loaded_d = words_loaded_q + 1'b1;
`ifdef LC2K_LOADER_CSUM_EN
                    acc_d          = acc_q + word;
`endif
                end
            end

`ifdef LC2K_LOADER_CSUM_EN
            S_CSUM: begin
                if (last_byte) begin
                    if (word == acc_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Data already written stays in memory
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
                end
            end
`endif

            S_DONE: begin
                state_d    = S_IDLE;
                cpu_hold_d = 1'b0;
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= 2'd0;
            shift_q        <= '0;
            len_q          <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cpu_hold_q     <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
`ifdef LC2K_LOADER_CSUM_EN
            acc_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            len_q          <= len_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_hold_q     <= cpu_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
`ifdef LC2K_LOADER_CSUM_EN
            acc_q          <= acc_d;
`endif
        end
    end

    // Registered outputs
    always_comb begin
        mem_we       = mem_we_q;
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        cpu_hold     = cpu_hold_q;
        done         = done_q;
        err          = err_q;
        words_loaded = words_loaded_q;
    end

endmodule

// File: tb/tb_lc2k_prog_loader.sv
// tb_lc2k_prog_loader: directed bench for the LC2K program loader.
// Table of load scenarios plus hand-written reset, start/in_valid and timing sequences.
// Memory writes and done pulses are captured on the falling edge.
module tb_lc2k_prog_loader;

    localparam int ADDR_W    = 4;
    localparam int MAX_WORDS = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    lc2k_prog_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       len;
        int                nsend;
        logic [9:0][31:0]  w;
        bit                gaps;
        bit                spam;
        logic [31:0]       csum_delta;
        int                exp_words;
        bit                exp_done;
        bit                exp_err;
    } vec_t;

    vec_t tbl [8];
    int   nrows;
    int   checks = 0;
    int   errors = 0;

    // Write/done monitor
    logic [ADDR_W-1:0] wq_addr [$];
    logic [31:0]       wq_data [$];
    logic              wq_rdy  [$];
    int                done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            wq_rdy.push_back(in_ready);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit spam);
        int  g;
        bit  ok;
        if (gaps) begin
            g = int'($urandom_range(0, 2));
            repeat (g) begin
                in_valid = 1'b0;
                start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = in_ready;
            tick();
        end
        check("byte_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, input bit spam);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gaps, spam);
    endtask

    task automatic wait_release();
        for (int n = 0; n < 40 && cpu_hold; n++) tick();
        check("hold_released", 32'(cpu_hold), 32'd0);
    endtask

    task automatic run_row(input int r);
        vec_t        v;
        logic [31:0] sum;
        int          base;
        int          dbase;
        v     = tbl[r];
        base  = wq_addr.size();
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_err", 32'(err), 32'd0);
        check("start_sets_hold", 32'(cpu_hold), 32'd1);
        send_word(v.len, v.gaps, 1'b0);
        sum = 32'd0;
        for (int i = 0; i < v.nsend; i++) begin
            send_word(v.w[i], v.gaps, v.spam);
            sum = sum + v.w[i];
        end
`ifdef LC2K_LOADER_CSUM_EN
        if (v.len <= 32'(MAX_WORDS)) send_word(sum + v.csum_delta, v.gaps, 1'b0);
`endif
        wait_release();
        tick();
        tick();
        check("num_writes", 32'(wq_addr.size() - base), 32'(v.exp_words));
        for (int i = 0; i < v.exp_words && (base + i) < wq_addr.size(); i++) begin
            check("wr_addr", 32'(wq_addr[base + i]), 32'(i));
            check("wr_data", wq_data[base + i], v.w[i]);
            check("rdy_low_on_we", 32'(wq_rdy[base + i]), 32'd0);
        end
        check("done_pulses", 32'(done_cnt - dbase), 32'(v.exp_done));
        check("err", 32'(err), 32'(v.exp_err));
        check("words_loaded", 32'(words_loaded), 32'(v.exp_words));
        if (v.exp_err) begin
            repeat (3) tick();
            check("err_sticky", 32'(err), 32'd1);
            check("hold_after_err", 32'(cpu_hold), 32'd0);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] len, input int nsend,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input bit gaps, input bit spam, input logic [31:0] cd,
                                input int ew, input bit ed, input bit ee);
        vec_t v;
        v            = '0;
        v.len        = len;
        v.nsend      = nsend;
        v.w[0]       = w0;
        v.w[1]       = w1;
        v.w[2]       = w2;
        v.gaps       = gaps;
        v.spam       = spam;
        v.csum_delta = cd;
        v.exp_words  = ew;
        v.exp_done   = ed;
        v.exp_err    = ee;
        return v;
    endfunction

    initial begin
        int base;
        int dbase;

        // Scenario table: len, words sent, first words, gaps, start spam, csum delta, expected words/done/err
        tbl[0] = mk(32'd3, 3, 32'h00810007, 32'h01530000, 32'h01000003, 1'b0, 1'b0, 32'd0, 3, 1'b1, 1'b0);
        tbl[1] = mk(32'd0, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 0, 1'b1, 1'b0);
        tbl[2] = mk(32'd11, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 0, 1'b0, 1'b1);
        tbl[3] = mk(32'd3, 3, 32'h00810007, 32'h01530000, 32'h01000003, 1'b1, 1'b1, 32'd0, 3, 1'b1, 1'b0);
        tbl[4] = mk(32'd10, 10, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 10, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tbl[4].w[i] = 32'hC0DE0000 | 32'(i);
        tbl[5] = mk(32'd1, 1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1'b1, 32'd0, 1, 1'b1, 1'b0);
        nrows = 6;
`ifdef LC2K_LOADER_CSUM_EN
        tbl[6] = mk(32'd2, 2, 32'h00000005, 32'h00000007, 32'd0, 1'b0, 1'b0, 32'd0, 2, 1'b1, 1'b0);
        tbl[7] = mk(32'd2, 2, 32'h00000005, 32'h00000007, 32'd0, 1'b0, 1'b0, 32'd1, 2, 1'b0, 1'b1);
        nrows = 8;
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        tick();

        // start with a byte already valid: byte not consumed, then N=0 done timing
        base     = wq_addr.size();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        check("idle_start_rdy", 32'(in_ready), 32'd0);
        tick();
        start = 1'b0;
        check("len_hold", 32'(cpu_hold), 32'd1);
        check("len_rdy", 32'(in_ready), 32'd1);
        send_word(32'd0, 1'b0, 1'b0);
`ifdef LC2K_LOADER_CSUM_EN
        send_word(32'd0, 1'b0, 1'b0);
`endif
        check("n0_done_now", 32'(done), 32'd1);
        check("n0_hold_in_done", 32'(cpu_hold), 32'd1);
        check("n0_err", 32'(err), 32'd0);
        tick();
        check("n0_done_single", 32'(done), 32'd0);
        check("n0_hold_drop", 32'(cpu_hold), 32'd0);
        check("n0_no_writes", 32'(wq_addr.size() - base), 32'd0);
        tick();

        // Reset in the middle of DATA after two words
        base  = wq_addr.size();
        dbase = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'd3, 1'b0, 1'b0);
        send_word(32'h11111111, 1'b0, 1'b0);
        send_word(32'h22222222, 1'b0, 1'b0);
        tick();
        tick();
        check("mid_words_loaded", 32'(words_loaded), 32'd2);
        check("mid_writes", 32'(wq_addr.size() - base), 32'd2);
        in_valid = 1'b1;
        in_data  = 8'h33;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_words", 32'(words_loaded), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_done", 32'(done_cnt - dbase), 32'd0);

        // Table-driven loads
        for (int r = 0; r < nrows; r++) run_row(r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
